// File: rtl/fir_interp_2x.sv
// fir_interp_2x: 2x interpolating 17-tap low-pass FIR on packed signed I/Q.
// Polyphase form: each accepted input yields an even-phase sample (P0) and
// an odd-phase sample (P1), so the zero-stuffed samples are never multiplied.
module fir_interp_2x #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int COEFF_WIDTH            = 8,
  parameter int SHIFT                  = 6
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready
);

  localparam int SW    = C_S00_AXIS_TDATA_WIDTH / 2;
  localparam int OW    = C_M00_AXIS_TDATA_WIDTH / 2;
  localparam int PW    = SW + COEFF_WIDTH;
  localparam int ACC_W = 28;
  localparam int NTAP  = 17;
  localparam int NLINE = 9;

  localparam logic signed [COEFF_WIDTH-1:0] H [NTAP] = '{
    -8'sd1, -8'sd2, -8'sd2, 8'sd0, 8'sd6, 8'sd13, 8'sd21, 8'sd27, 8'sd29,
    8'sd27, 8'sd21, 8'sd13, 8'sd6, 8'sd0, -8'sd2, -8'sd2, -8'sd1
  };

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OW - 1)));

  typedef enum logic [1:0] {IDLE, PH0, PH1} state_t;

  // Full-precision signed product of one sample and one tap.
  function automatic logic signed [PW-1:0] mul(input logic signed [SW-1:0] x,
                                               input logic signed [COEFF_WIDTH-1:0] h);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] he;
    xe = PW'(x);
    he = PW'(h);
    return xe * he;
  endfunction

  // Floor shift of the accumulator, then clamp to the output range.
  function automatic logic signed [OW-1:0] shift_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SHIFT;
    if (sh > SAT_HI)      return SAT_HI[OW-1:0];
    else if (sh < SAT_LO) return SAT_LO[OW-1:0];
    else                  return sh[OW-1:0];
  endfunction

  state_t                    state_q;
  logic signed [SW-1:0]      xi_q [NLINE];
  logic signed [SW-1:0]      xq_q [NLINE];
  logic signed [SW-1:0]      xi_d [NLINE];
  logic signed [SW-1:0]      xq_d [NLINE];
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] p1_q;
  logic                      last_q;
  logic                      m_tvalid_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_tdata_q;
  logic                      m_tlast_q;

  logic signed [ACC_W-1:0]   p0i_acc, p0q_acc, p1i_acc, p1q_acc;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] p0_pack, p1_pack;
  logic                      accept;

  // Input can be taken when idle, or when the odd phase leaves this cycle.
  always_comb begin
    s00_axis_tready = (state_q == IDLE) || ((state_q == PH1) && m00_axis_tready);
    accept          = s00_axis_tvalid && s00_axis_tready;
  end

  // Post-shift delay line and both polyphase sums for I and Q.
  always_comb begin
    xi_d[0] = s00_axis_tdata[SW-1:0];
    xq_d[0] = s00_axis_tdata[2*SW-1:SW];
    for (int k = 1; k < NLINE; k++) begin
      xi_d[k] = xi_q[k-1];
      xq_d[k] = xq_q[k-1];
    end
    p0i_acc = '0;
    p0q_acc = '0;
    p1i_acc = '0;
    p1q_acc = '0;
    for (int k = 0; k < NLINE; k++) begin
      p0i_acc = p0i_acc + ACC_W'(mul(xi_d[k], H[2*k]));
      p0q_acc = p0q_acc + ACC_W'(mul(xq_d[k], H[2*k]));
    end
    for (int k = 0; k < NLINE - 1; k++) begin
      p1i_acc = p1i_acc + ACC_W'(mul(xi_d[k], H[2*k+1]));
      p1q_acc = p1q_acc + ACC_W'(mul(xq_d[k], H[2*k+1]));
    end
    p0_pack = {shift_sat(p0q_acc), shift_sat(p0i_acc)};
    p1_pack = {shift_sat(p1q_acc), shift_sat(p1i_acc)};
  end

  // History update and phase sequencing with registered stream outputs.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q    <= IDLE;
      for (int k = 0; k < NLINE; k++) begin
        xi_q[k] <= '0;
        xq_q[k] <= '0;
      end
      p1_q       <= '0;
      last_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < NLINE; k++) begin
        xi_q[k] <= xi_d[k];
        xq_q[k] <= xq_d[k];
      end
      state_q    <= PH0;
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= p0_pack;
      m_tlast_q  <= 1'b0;
      p1_q       <= p1_pack;
      last_q     <= s00_axis_tlast;
    end else begin
      case (state_q)
        PH0: begin
          if (m00_axis_tready) begin
            state_q   <= PH1;
            m_tdata_q <= p1_q;
            m_tlast_q <= last_q;
          end
        end
        PH1: begin
          if (m00_axis_tready) begin
            state_q    <= IDLE;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tdata  = m_tdata_q;
  assign m00_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_fir_interp_2x.sv
// Bench for fir_interp_2x: scoreboard fed by a zero-stuff-then-convolve model.
module tb_fir_interp_2x;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  fir_interp_2x dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   up_i[$];
  int   up_q[$];
  int   log_i[$];
  int   log_q[$];
  int   log_cyc[$];
  int   acc_cyc[$];
  bit   log_l[$];

  int h[17]       = '{-1, -2, -2, 0, 6, 13, 21, 27, 29, 27, 21, 13, 6, 0, -2, -2, -1};
  int imp_ref[20] = '{-16, -32, -32, 0, 93, 203, 328, 421, 453, 421, 328, 203, 93, 0,
                      -32, -32, -16, 0, 0, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Output of the prototype filter applied to the zero-stuffed stream, newest first.
  function automatic int fir_at(input bit use_q);
    int acc = 0;
    int v;
    for (int j = 0; j < 17; j++) begin
      v = 0;
      if (use_q) begin
        if (j < up_q.size()) v = up_q[j];
      end else begin
        if (j < up_i.size()) v = up_i[j];
      end
      acc += h[j] * v;
    end
    return sat16(acc >>> 6);
  endfunction

  function automatic logic [31:0] pack(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = i[15:0];
    b = q[15:0];
    return {b, a};
  endfunction

  function automatic int rnd16();
    int r = $urandom_range(0, 7);
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($signed(16'($urandom)));
  endfunction

  // Accepted input: interpolate by inserting a zero after it, filter each sample.
  task automatic model_push(input int i, input int q, input bit last);
    exp_t e;
    up_i.push_front(i);
    up_q.push_front(q);
    e.d = pack(fir_at(0), fir_at(1));
    e.l = 1'b0;
    exp_q.push_back(e);
    up_i.push_front(0);
    up_q.push_front(0);
    e.d = pack(fir_at(0), fir_at(1));
    e.l = last;
    exp_q.push_back(e);
    while (up_i.size() > 17) begin
      void'(up_i.pop_back());
      void'(up_q.pop_back());
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every output handshake is checked against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", m_tdata, mon_e.d);
        chk("out_last", m_tlast, mon_e.l);
      end
      log_i.push_back(int'($signed(m_tdata[15:0])));
      log_q.push_back(int'($signed(m_tdata[31:16])));
      log_l.push_back(m_tlast);
      log_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    log_i.delete();
    log_q.delete();
    log_l.delete();
    log_cyc.delete();
    acc_cyc.delete();
  endtask

  // Present one input and hold it until accepted; returns on the accepting edge.
  task automatic send(input int i, input int q, input bit last);
    int t = 0;
    bit done = 0;
    #1;
    s_tvalid = 1'b1;
    s_tdata  = pack(i, q);
    s_tlast  = last;
    while (!done && t < 100) begin
      @(negedge clk);
      if (s_tready) begin
        model_push(i, q, last);
        acc_cyc.push_back(cyc);
        done = 1;
      end
      @(posedge clk);
      t++;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
  endtask

  task automatic run_impulse(input string tag);
    clear_logs();
    send(1000, 0, 0);
    for (int k = 0; k < 9; k++) send(0, 0, 0);
    idle();
    drain();
    chk({tag, "_count"}, log_i.size(), 20);
    for (int k = 0; k < 20; k++) begin
      chk({tag, "_i"}, (k < log_i.size()) ? log_i[k] : 99999, imp_ref[k]);
      chk({tag, "_q"}, (k < log_q.size()) ? log_q[k] : 99999, 0);
    end
  endtask

  initial begin
    int  cur_i, cur_q;
    bit  cur_l, pending;

    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_m_tdata", m_tdata, 0);
    chk("reset_m_tlast", m_tlast, 0);
    chk("reset_s_tready", s_tready, 1);
    @(posedge clk);

    // Impulse response from a clean history
    run_impulse("impulse");

    // DC steady state
    clear_logs();
    for (int k = 0; k < 12; k++) send(1000, 1000, 0);
    idle();
    drain();
    for (int k = 18; k < 24; k++) begin
      chk("dc_i", (k < log_i.size()) ? log_i[k] : 99999, (k % 2 == 0) ? 1203 : 1187);
      chk("dc_q", (k < log_q.size()) ? log_q[k] : 99999, (k % 2 == 0) ? 1203 : 1187);
    end

    // Saturation at both rails
    clear_logs();
    for (int k = 0; k < 12; k++) send(32767, -32768, 0);
    idle();
    drain();
    for (int k = 18; k < 24; k++) begin
      chk("sat_i", (k < log_i.size()) ? log_i[k] : 99999, 32767);
      chk("sat_q", (k < log_q.size()) ? log_q[k] : 99999, -32768);
    end

    // Backpressure during PH0 with a waiting input
    #1 m_tready = 1'b0;
    send(500, -700, 0);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = pack(1234, -4321);
    s_tlast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_m_tvalid", m_tvalid, 1);
      chk("bp_m_tdata", m_tdata, (exp_q.size() > 0) ? exp_q[0].d : 0);
      chk("bp_s_tready", s_tready, 0);
      @(posedge clk);
    end
    chk("bp_no_consume", exp_q.size(), 2);
    #1 m_tready = 1'b1;
    send(1234, -4321, 0);
    idle();
    drain();

    // Throughput and tlast placement
    clear_logs();
    send(rnd16(), rnd16(), 0);
    send(rnd16(), rnd16(), 0);
    send(rnd16(), rnd16(), 0);
    send(rnd16(), rnd16(), 1);
    idle();
    drain();
    chk("tp_count", log_l.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("tp_tlast", (k < log_l.size()) ? log_l[k] : 1'b0, (k == 7) ? 1 : 0);
    for (int k = 1; k < 8; k++)
      chk("tp_out_gap", (k < log_cyc.size()) ? log_cyc[k] - log_cyc[k-1] : 0, 1);
    for (int k = 1; k < 4; k++)
      chk("tp_in_spacing", (k < acc_cyc.size()) ? acc_cyc[k] - acc_cyc[k-1] : 0, 2);

    // Reset while the odd phase is pending
    #1 m_tready = 1'b0;
    send(1000, 0, 0);
    #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("pre_reset_in_ph1", m_tvalid, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    up_i.delete();
    up_q.delete();
    m_tready = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s_tready", s_tready, 1);
    chk("midrst_m_tdata", m_tdata, 0);
    @(posedge clk);
    run_impulse("impulse_after_reset");

    // Randomized traffic with random downstream stalls and tlast
    pending = 0;
    cur_i = 0;
    cur_q = 0;
    cur_l = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          cur_i    = rnd16();
          cur_q    = rnd16();
          cur_l    = ($urandom_range(0, 7) == 0);
          s_tdata  = pack(cur_i, cur_q);
          s_tlast  = cur_l;
          s_tvalid = 1'b1;
          pending  = 1;
        end
      end
      @(negedge clk);
      if (pending && s_tready) begin
        model_push(cur_i, cur_q, cur_l);
        pending = 0;
      end
    end
    @(posedge clk);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
